// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_pkg
// Purpose  : Shared types for the instruction-fetch stage. Holds the fetch
//            entry handed to decode, the fetch FSM encoding and the reset PC.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

  // Default boot vector (MIPS kseg1 reset exception address)
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  // Fetch FSM: issue request, wait for response, hold entry for decode
  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Entry handed from fetch to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        delay_slot;
    logic        jump;
  } fetch_data_t;

  // Clears the byte offset of an address
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_sel.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_sel
// Purpose  : Combinational next-PC select for the fetch stage. A flush wins,
//            then a pending branch target once its delay slot has been
//            handed over, otherwise sequential pc+4 (wraps at 2^32).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_sel
  import fetch_stage_pkg::*;
(
  input  logic [31:0] entry_pc,
  input  logic        pend_valid,
  input  logic [31:0] pend_target,
  input  logic        delay_slot,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] next_pc,
  output logic        next_is_target
);

  // Priority select of the PC to fetch next
  always_comb begin
    next_pc        = entry_pc + 32'd4;
    next_is_target = 1'b0;
    if (flush) begin
      next_pc = flush_pc;
    end else if (pend_valid && delay_slot) begin
      next_pc        = pend_target;
      next_is_target = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : MIPS instruction-fetch stage. Owns the PC, keeps one request in
//            flight, buffers one instruction for decode and applies
//            delay-slot redirects and flushes (with stale-response dropping).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = RESET_PC_DEFAULT,
  parameter bit          ADDR_ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_data_t out_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        flush_valid,
  input  logic [31:0] flush_pc
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         is_target_q, is_target_d;    // pc_q came from a branch target
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic         buf_jump_q, buf_jump_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
  logic         ds_pending_q, ds_pending_d;
  logic [1:0]   drop_cnt_q, drop_cnt_d;

  logic [31:0]  redir_tgt, flush_tgt;
  logic         redirect_eff, ds_now, drop_inc, drop_dec;
  logic [31:0]  sel_pc;
  logic         sel_is_target;

  generate
    if (ADDR_ALIGN_CHECK) begin : g_align
      assign redir_tgt = word_align(redirect_target);
      assign flush_tgt = word_align(flush_pc);
    end else begin : g_no_align
      assign redir_tgt = redirect_target;
      assign flush_tgt = flush_pc;
    end
  endgenerate

  // A flush in the same cycle cancels the redirect entirely
  assign redirect_eff = redirect_valid && !flush_valid;
  // The entry handed over now is the delay slot if a redirect is pending or arriving
  assign ds_now       = ds_pending_q || redirect_eff;

  // Requests are held off while stale responses are still owed; the reset
  // term keeps the request low while the async reset is asserted
  assign ireq_valid = reset && (state_q == REQ) && (drop_cnt_q == 2'd0);
  assign ireq_addr  = pc_q;
  assign out_valid  = (state_q == HOLD);

  // Present the buffered entry; delay_slot reflects redirects seen so far
  always_comb begin
    out_data             = '0;
    out_data.pc          = buf_pc_q;
    out_data.instruction = buf_instr_q;
    out_data.jump        = buf_jump_q;
    out_data.delay_slot  = (state_q == HOLD) && ds_now;
  end

  fetch_pc_sel u_pc_sel (
    .entry_pc       (buf_pc_q),
    .pend_valid     (pend_valid_q || redirect_eff),
    .pend_target    (redirect_eff ? redir_tgt : pend_target_q),
    .delay_slot     (ds_now),
    .flush          (flush_valid),
    .flush_pc       (flush_tgt),
    .next_pc        (sel_pc),
    .next_is_target (sel_is_target)
  );

  // Stale-response accounting: count requests orphaned by a flush
  always_comb begin
    drop_inc   = flush_valid &&
                 (((state_q == WAIT) && !iresp_data_ok) || (ireq_valid && ireq_addr_ok));
    drop_dec   = iresp_data_ok && (drop_cnt_q != 2'd0);
    drop_cnt_d = drop_cnt_q;
    if (drop_inc && !drop_dec) begin
      if (drop_cnt_q != 2'd3) drop_cnt_d = drop_cnt_q + 2'd1;
    end else if (drop_dec && !drop_inc) begin
      drop_cnt_d = drop_cnt_q - 2'd1;
    end
  end

  // Fetch FSM, buffer load and redirect/flush bookkeeping
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    is_target_d   = is_target_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_jump_d    = buf_jump_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    ds_pending_d  = ds_pending_q;

    if (redirect_eff) begin
      pend_target_d = redir_tgt;
      pend_valid_d  = 1'b1;
      ds_pending_d  = 1'b1;
    end

    case (state_q)
      REQ: begin
        if (ireq_valid && ireq_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (iresp_data_ok && (drop_cnt_q == 2'd0)) begin
          state_d     = HOLD;
          buf_pc_d    = pc_q;
          buf_instr_d = iresp_data;
          buf_jump_d  = is_target_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d     = REQ;
          pc_d        = sel_pc;
          is_target_d = sel_is_target;
          if (ds_now) ds_pending_d = 1'b0;
          if (sel_is_target) pend_valid_d = 1'b0;
        end
      end
      default: state_d = REQ;
    endcase

    if (flush_valid) begin
      state_d      = REQ;
      pc_d         = sel_pc;
      is_target_d  = 1'b0;
      pend_valid_d = 1'b0;
      ds_pending_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      is_target_q   <= 1'b0;
      buf_pc_q      <= '0;
      buf_instr_q   <= '0;
      buf_jump_q    <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      ds_pending_q  <= 1'b0;
      drop_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      is_target_q   <= is_target_d;
      buf_pc_q      <= buf_pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_jump_q    <= buf_jump_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      ds_pending_q  <= ds_pending_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // More than three orphaned requests would overflow the drop counter
  a_drop_cnt_sat: assert property (@(posedge clk) disable iff (!reset)
    !(drop_inc && !drop_dec && (drop_cnt_q == 2'd3)));

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC and issues one instruction-bus request at a time.
- Buffers one returned instruction and hands it to decode as a fetch_data_t entry {pc, instruction, delay_slot, jump} using a valid/ready handshake.
- Applies branch/jump redirects from decode with MIPS delay-slot semantics, and full flushes from the exception path.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC of the first fetch after reset.
- ADDR_ALIGN_CHECK, 1, when 1, redirect/flush targets with addr[1:0]!=0 are forced to word alignment.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  instruction request valid.
- ireq_addr  out  32  request address (word aligned).
- ireq_addr_ok  in  1  request accepted this cycle.
- iresp_data_ok  in  1  response valid this cycle.
- iresp_data  in  32  instruction word.
- out_valid  out  1  fetch entry valid to decode.
- out_ready  in  1  decode accepts the entry this cycle.
- out_data  out  fetch_data_t  entry to decode.
- redirect_valid  in  1  decode holds a taken branch/jump this cycle.
- redirect_target  in  32  branch/jump target.
- flush_valid  in  1  discard all fetch state.
- flush_pc  in  32  restart PC for the flush.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, state=REQ.
  - ireq_valid=0, out_valid=0, out_data=0.
  - pend_valid=0, ds_pending=0, drop_cnt=0.
- Fetch FSM states:
  - REQ: drive ireq_valid=1 and ireq_addr=pc. On ireq_addr_ok, go to WAIT.
  - WAIT: request outstanding, ireq_valid=0. On iresp_data_ok (and drop_cnt==0), load the buffer and go to HOLD.
  - HOLD: out_valid=1. On out_ready, advance pc and go to REQ.
- First-cycle ireq_valid after reset release is 1.
- Latency:
  - Minimum 3 cycles from a request to out_valid (REQ, WAIT, response registered).
  - Only one request is ever outstanding; no prefetch beyond the buffer.
- Next-PC on a HOLD→REQ transition:
  - If pend_valid and the entry just transferred had delay_slot=1: pc=pend_target and clear pend_valid.
  - Otherwise pc=entry.pc+4 (32-bit wrap, 32'hFFFF_FFFC+4 → 0).
- Redirect and delay slot:
  - On redirect_valid: pend_target=redirect_target, pend_valid=1, ds_pending=1.
  - The first entry that completes out_valid&&out_ready at or after the redirect cycle is the delay slot: delay_slot=1, clear ds_pending.
  - This covers a same-cycle transfer, and an entry already buffered, in flight, or not yet requested.
  - The first entry fetched from pend_target carries jump=1. All other entries carry jump=0 and delay_slot=0.
  - A second redirect while pend_valid=1 overwrites pend_target. Decode guarantees this occurs only for branch-in-delay-slot, which is undefined architecturally but must not hang.
- Flush, which has priority over redirect in the same cycle:
  - Next cycle: pc=flush_pc, state=REQ, out_valid=0, pend_valid=0, ds_pending=0.
  - If flushed in WAIT (response outstanding), increment drop_cnt. Responses with drop_cnt>0 decrement it and are discarded, and no REQ is issued while drop_cnt>0.
  - A response arriving in the flush cycle itself is discarded and needs no drop_cnt.
  - Flush in REQ without ireq_addr_ok: just retarget. With ireq_addr_ok in the same cycle: treat the request as outstanding and count it.
- Stall: out_ready=0 holds out_valid and out_data stable. Required while out_valid=1 and out_ready=0.
- ireq_addr must stay stable while ireq_valid=1 and ireq_addr_ok=0, unless flush_valid.
- Reset mid-transaction: all state returns to reset values immediately. The bus side is reset together, so no drop tracking is required.

Decomposition:
- The pipes package holds the fetch_data_t (existing), RESET_PC default, and a fetch_state_t enum {REQ, WAIT, HOLD}.
- One natural sub-module: fetch_pc_sel, a combinational next-PC select. Its inputs are entry pc, pend_target/pend_valid, delay_slot of the transferring entry, and flush.
- Buffer, FSM and drop counter (2 bits, saturating at 3 with an assertion) stay in fetch_stage.

Test Plan:
- Reset release, ireq_addr_ok and iresp_data_ok each 1 cycle after the request, out_ready=1:
  - out_data.pc sequence is BFC0_0000, BFC0_0004, BFC0_0008.
  - jump=0 and delay_slot=0 on all three.
- out_ready=0 for 5 cycles while out_valid=1:
  - out_data is unchanged every cycle and ireq_valid=0.
  - The next request goes to pc+4 only after out_ready.
- Redirect to 0x0000_1000 while the entry at 0xBFC0_0008 sits in HOLD:
  - 0xBFC0_0008 is delivered with delay_slot=1.
  - The next entry has pc=0x1000 and jump=1; the following entry is 0x1004 with jump=0.
- Redirect while the request for 0xBFC0_000C is in WAIT:
  - 0xBFC0_000C is delivered with delay_slot=1.
  - Then target with jump=1, and no fetch of 0xBFC0_0010.
- Flush to 0x8000_0180 during WAIT:
  - The stale response is discarded (never out_valid).
  - The next request is 0x8000_0180, and its entry has jump=0, delay_slot=0.
- Flush and redirect in the same cycle, plus async reset asserted mid-WAIT:
  - Flush wins: pc=flush_pc and pend_valid=0.
  - The reset returns ireq_valid=0 and out_valid=0 immediately, then the first request is RESET_PC.
